fas_analysis: RTL and testbench
===============================

# fas_analysis

Frequency-analysis stage of the FAS datapath, directly downstream of the 16-point FFT. It captures one 16-bin spectrum on each `fft_valid` pulse and computes |X[k]|² = re² + im² for one bin per cycle. It reports the index of the largest-magnitude bin on `freq`, with a one-cycle `done` pulse. Ties resolve to the lower index, so a real input tone reports bin 1 rather than its mirror bin 15.

## Interface
- `DW`, default 16: width of each real/imag component, signed two's complement, 8.8 fixed point.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fft_valid`  in  1  one-cycle strobe; `fft_d0..fft_d15` are valid in this cycle.
- `fft_d0` … `fft_d15`  in  2*DW each  bin k: real in [2*DW-1:DW], imag in [DW-1:0].
- `done`  out  1  one-cycle pulse; `freq` is updated for the new frame.
- `freq`  out  4  index of the peak bin of the last completed frame.
- `busy`  out  1  high while a frame is being scanned.
- `ovf`  out  1  sticky; a `fft_valid` arrived when it could not be accepted.

## Operation
- States: IDLE and SCAN. A 4-bit bin counter `idx`. Capture bank of 16 × 2*DW registers. `best_mag` is 2*DW bits unsigned. `best_idx` is 4 bits.
- Accept condition: `fft_valid` && (state==IDLE || (state==SCAN && idx==15)).
- On accept:
  - Load all 16 bins into the capture bank.
  - Go to (or stay in) SCAN with idx=0.
- SCAN, each edge:
  - Compute mag = re[idx]² + im[idx]² as a full-precision signed product per term, summed as an unsigned 2*DW-bit value. The maximum is 2^(2*DW-1) for (0x8000, 0x8000), so the sum cannot overflow.
  - At idx==0: best_mag←mag, best_idx←0 unconditionally.
  - At idx>0: if mag > best_mag (strictly greater), then best_mag←mag, best_idx←idx.
  - idx←idx+1.
- At the idx==15 edge:
  - freq←final winner, i.e. including the bin-15 comparison done in the same edge.
  - done←1.
  - If no accept occurs on that edge, return to IDLE.
  - If an accept occurs on that edge, restart SCAN with idx=0 and the new bank; the old frame's result is still delivered.
- `fft_valid` in SCAN with idx≠15:
  - Ignored; the capture bank and scan are unaffected.
  - ovf←1 and stays set until `rst`.
- `busy` = (state==SCAN).
- `freq` holds its value between `done` pulses.
- `rst` at any time, including mid-scan:
  - state=IDLE, idx=0, done=0, freq=0, ovf=0, best_mag=0, best_idx=0.
  - The frame in flight is discarded and no `done` is produced for it.
  - `rst` has priority over `fft_valid` in the same cycle.

## Timing
- Reset values of outputs: done=0, freq=0, busy=0, ovf=0.
- Accept edge E0 → bins 0..15 are evaluated on edges E1..E16.
- `done` is high in the cycle after E16 only. Latency from the accepting edge to `done` visible is 16 cycles.
- `busy` rises after E0. It falls after E16 unless a back-to-back accept occurred at E16.
- Sustained throughput is one frame per 16 cycles. This matches FAS, where the FFT emits one frame per 16 FIR samples, aligned so that the next `fft_valid` lands on the idx==15 edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single frame: bin 1 = 0x0100_0000, bin 15 = 0x0100_0000, all others 0. Required: `done` 16 cycles after `fft_valid`, freq=1 (tie → lower index), busy low afterwards.
- Peak at bin 15 only: bin 15 = 0x0000_FF00 (im = -1.0), all others 0x0001_0001. Required: freq=15. Also checks that the last bin is included in the result.
- Extremes: bin 7 = 0x8000_8000, bin 3 = 0x7FFF_7FFF. Required: freq=7, confirming the magnitude is unsigned with no overflow.
- Back-to-back: frame A (peak at bin 4), then `fft_valid` exactly 16 cycles later with frame B (peak at bin 9). Required:
  - done pulses 16 cycles apart, freq=4 then freq=9.
  - busy continuously high between the two accepts.
  - ovf=0.
- Overrun: `fft_valid` at idx=5 of a scan, carrying a frame with its peak at bin 2 (original frame's peak at bin 12). Required: done shows freq=12, ovf=1, and ovf remains set until `rst`.
- Reset mid-scan: assert `rst` at idx=8. Required:
  - No `done` is produced.
  - freq=0, busy=0, ovf=0.
  - The next frame processes normally with 16-cycle latency.

Source files
------------

// File: rtl/fas_analysis.sv
// Frequency-analysis stage: captures a 16-bin FFT frame and scans one bin per cycle
// for the peak |X[k]|^2. Ties go to the lower index.
module fas_analysis #(
    parameter int unsigned DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            done,
    output logic [3:0]      freq,
    output logic            busy,
    output logic            ovf
);
    localparam int unsigned BW = 2 * DW;
    localparam int unsigned NB = 16;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      idx, idx_nxt;
    logic [BW-1:0]   best_mag, best_mag_nxt;
    logic [3:0]      best_idx, best_idx_nxt;
    logic [3:0]      freq_nxt;
    logic            done_nxt;
    logic            ovf_nxt;
    logic            load;
    logic [BW-1:0]   bank [NB];
    logic [BW-1:0]   din  [NB];

    logic signed [DW-1:0] re, im;
    logic signed [BW-1:0] re_sq, im_sq;
    logic [BW-1:0]        mag;

    assign din[0]  = fft_d0;
    assign din[1]  = fft_d1;
    assign din[2]  = fft_d2;
    assign din[3]  = fft_d3;
    assign din[4]  = fft_d4;
    assign din[5]  = fft_d5;
    assign din[6]  = fft_d6;
    assign din[7]  = fft_d7;
    assign din[8]  = fft_d8;
    assign din[9]  = fft_d9;
    assign din[10] = fft_d10;
    assign din[11] = fft_d11;
    assign din[12] = fft_d12;
    assign din[13] = fft_d13;
    assign din[14] = fft_d14;
    assign din[15] = fft_d15;

    assign busy = (state == SCAN);

    // Next-state, scan datapath and output decode
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        best_mag_nxt = best_mag;
        best_idx_nxt = best_idx;
        freq_nxt     = freq;
        done_nxt     = 1'b0;
        ovf_nxt      = ovf;
        load         = 1'b0;

        re    = bank[idx][BW-1:DW];
        im    = bank[idx][DW-1:0];
        re_sq = BW'(re) * BW'(re);
        im_sq = BW'(im) * BW'(im);
        // Each square is at most 2^(BW-2), so the unsigned sum cannot wrap
        mag   = $unsigned(re_sq) + $unsigned(im_sq);

        case (state)
            IDLE: begin
                if (fft_valid) begin
                    load      = 1'b1;
                    idx_nxt   = 4'd0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == 4'd0 || mag > best_mag) begin
                    best_mag_nxt = mag;
                    best_idx_nxt = idx;
                end
                idx_nxt = idx + 4'd1;
                if (idx == 4'd15) begin
                    freq_nxt = (mag > best_mag) ? 4'd15 : best_idx;
                    done_nxt = 1'b1;
                    if (fft_valid) begin
                        load    = 1'b1;
                        idx_nxt = 4'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (fft_valid) begin
                    ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            best_mag <= '0;
            best_idx <= 4'd0;
            freq     <= 4'd0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            best_mag <= best_mag_nxt;
            best_idx <= best_idx_nxt;
            freq     <= freq_nxt;
            done     <= done_nxt;
            ovf      <= ovf_nxt;
        end
    end

    // Capture bank; no reset needed since it is only read during SCAN
    always_ff @(posedge clk) begin
        if (load && !rst) begin
            for (int i = 0; i < int'(NB); i++) begin
                bank[i] <= din[i];
            end
        end
    end
endmodule

// File: tb/tb_fas_analysis.sv
// Directed bench for fas_analysis: peak detection, ties, extremes, back-to-back,
// overrun and mid-scan reset, against hand-computed expectations.
module tb_fas_analysis;
    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic [31:0] fd [16];
    logic        done;
    logic [3:0]  freq;
    logic        busy;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    fas_analysis #(.DW(16)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
        .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
        .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
        .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
        .done(done), .freq(freq), .busy(busy), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 16; i++) fd[i] = v;
    endtask

    task automatic pulse();
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    // Cycles from now until done is seen, capped at 40
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < 40);
    endtask

    initial begin
        rst = 1'b1;
        fft_valid = 1'b0;
        fill(32'h0);
        repeat (3) tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_freq", 32'(freq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;
        tick();

        // Tie between bin 1 and its mirror bin 15
        fill(32'h0);
        fd[1]  = 32'h0100_0000;
        fd[15] = 32'h0100_0000;
        pulse();
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("t1_lat",  32'(n), 32'd16);
        check("t1_freq", 32'(freq), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        repeat (3) tick();
        check("t1_freq_hold", 32'(freq), 32'd1);

        // Last bin wins: im = -1.0
        fill(32'h0001_0001);
        fd[15] = 32'h0000_FF00;
        pulse();
        wait_done(n);
        check("t2_lat",  32'(n), 32'd16);
        check("t2_freq", 32'(freq), 32'd15);
        tick();

        // Most-negative components beat most-positive ones
        fill(32'h0);
        fd[7] = 32'h8000_8000;
        fd[3] = 32'h7FFF_7FFF;
        pulse();
        wait_done(n);
        check("t3_freq", 32'(freq), 32'd7);
        tick();

        // Back-to-back frames: A peaks at 4, B at 9
        fill(32'h0001_0000);
        fd[4] = 32'h0200_0000;
        pulse();
        for (int i = 0; i < 15; i++) begin
            check("t4_busy_a", 32'(busy), 32'd1);
            tick();
        end
        fill(32'h0000_0001);
        fd[9] = 32'h0000_0300;
        pulse();
        check("t4_done_a", 32'(done), 32'd1);
        check("t4_freq_a", 32'(freq), 32'd4);
        check("t4_busy_mid", 32'(busy), 32'd1);
        fill(32'h0);
        wait_done(n);
        check("t4_lat_b",  32'(n), 32'd16);
        check("t4_freq_b", 32'(freq), 32'd9);
        check("t4_ovf",    32'(ovf), 32'd0);
        tick();

        // Overrun at idx 5: original peak 12 must survive
        fill(32'h0);
        fd[12] = 32'h0050_0000;
        pulse();
        repeat (5) tick();
        fill(32'h0);
        fd[2] = 32'h7000_0000;
        pulse();
        check("t5_ovf_set", 32'(ovf), 32'd1);
        wait_done(n);
        check("t5_lat",  32'(n), 32'd10);
        check("t5_freq", 32'(freq), 32'd12);
        check("t5_ovf",  32'(ovf), 32'd1);
        repeat (5) tick();
        check("t5_ovf_sticky", 32'(ovf), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);

        // Reset at idx 8 discards the frame
        fill(32'h0);
        fd[6] = 32'h0100_0100;
        pulse();
        repeat (8) tick();
        rst = 1'b1;
        fft_valid = 1'b1;
        tick();
        rst = 1'b0;
        fft_valid = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_freq", 32'(freq), 32'd0);
        check("t6_ovf",  32'(ovf),  32'd0);
        check("t6_done", 32'(done), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n++;
        end
        check("t6_no_done", 32'(n), 32'd0);
        fill(32'h0);
        fd[10] = 32'hFF00_0000;
        pulse();
        wait_done(n);
        check("t6_lat",  32'(n), 32'd16);
        check("t6_freq", 32'(freq), 32'd10);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
